sram_burst_rw_fsm: RTL
======================

// Module: sram_burst_rw_fsm
// PURPOSE
//  Button-stepped SRAM write/read controller. Generalises the single-word switch/LED flow
//  with parametrised data/address width, burst length, auto-increment with wrap, and an
//  inferred on-chip RAM. Sits between the board debouncer and the LEDs in the SRAM demo.
// PARAMETERS
//  DATA_W  4  data word width; also width of sw and led
//  ADDR_W  4  address width; RAM depth = 2**ADDR_W; ADDR_W <= DATA_W
//  LEN_W   4  burst-length field width; LEN_W <= DATA_W
// PORTS
//  clock        in   1       system clock, all logic on posedge
//  n_reset      in   1       asynchronous, active-low reset
//  btn_pulse    in   1       one-cycle debounced press (step)
//  abort_pulse  in   1       one-cycle debounced press (abort; see CONFIGURATION)
//  mode_wr      in   1       1 = write burst, 0 = read burst; sampled only in IDLE
//  sw           in   DATA_W  address / length / write-data entry
//  led          out  DATA_W  last word read from RAM
//  busy         out  1       1 when state != IDLE
//  state_o      out  3       current state encoding (debug)
//  addr_o       out  ADDR_W  current burst address
// BEHAVIOUR
//  Reset: state=IDLE, led=0, addr_o=0, remaining=0, mode latch=0. RAM contents are not cleared.
//  Reset mid-burst aborts immediately; a partial burst is not undone.
//  States: IDLE=0 ADDR=1 LEN=2 WDATA=3 WRITE=4 RREQ=5 RWAIT=6 RSHOW=7.
//  - IDLE : press -> latch mode_wr -> ADDR.
//  - ADDR : press -> addr <= sw[ADDR_W-1:0] -> LEN.
//  - LEN  : press -> remaining <= sw[LEN_W-1:0], value 0 loaded as 1;
//           -> WDATA if write mode, else RREQ.
//  - WDATA: press -> wdata <= sw -> WRITE.
//  - WRITE: single cycle. RAM we=1 at addr. addr <= addr+1 (wraps 2**ADDR_W-1 -> 0).
//           remaining-1. -> IDLE if remaining was 1, else WDATA.
//  - RREQ : single cycle. RAM en=1 at addr -> RWAIT.
//  - RWAIT: RAM output is registered, 1-cycle latency. led <= rdata -> RSHOW.
//           led changes 2 cycles after RREQ is entered.
//  - RSHOW: holds the word on led. press -> addr+1 (wrap), remaining-1;
//           -> IDLE if remaining was 1, else RREQ.
//  Presses in WRITE/RREQ/RWAIT are dropped, not queued. mode_wr changes outside IDLE are ignored.
//  led changes only in RWAIT and on reset. It holds across writes and returns to IDLE.
//  Write-then-read of the same address in consecutive bursts returns the new data (no bypass needed).
// CONFIGURATION
//  SRAM_BURST_ABORT_EN defined:
//   - abort_pulse in any non-IDLE state forces IDLE on the next edge.
//   - abort has priority over a simultaneous btn_pulse.
//   - In WRITE, the write in that cycle still commits, then -> IDLE.
//   - In RWAIT, led still captures, then -> IDLE.
//   - addr_o and led keep their values.
//  SRAM_BURST_ABORT_EN undefined: abort_pulse is ignored; the port remains.
// TESTING
//  T1 write burst: mode_wr=1, addr=4'hE, len=3, data A,B,C
//     -> RAM[E]=A, RAM[F]=B, RAM[0]=C (wrap); busy drops after 3rd WRITE.
//  T2 read burst: mode_wr=0, addr=E, len=3 -> led shows A, B, C on successive RSHOW;
//     each appears 2 cycles after RREQ.
//  T3 len=0 -> exactly one write/read; remaining rule covered.
//  T4 btn_pulse held high during WRITE/RREQ/RWAIT -> no extra state advance.
//  T5 n_reset asserted in WDATA of a 3-word burst -> IDLE, led=0, addr_o=0;
//     previously written words stay intact on readback.
//  T6 ABORT_EN build: abort with btn in RSHOW -> IDLE, led holds.
//     Non-ABORT build: the same stimulus advances normally.

Source files
------------

// File: rtl/sram_burst_rw_fsm.sv
// Button-stepped SRAM burst write/read controller with an inferred RAM (1-cycle registered read).
// Optional abort support via `define SRAM_BURST_ABORT_EN; abort_pulse is ignored when undefined.
module sram_burst_rw_fsm #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              btn_pulse,
  input  logic              abort_pulse,
  input  logic              mode_wr,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [ADDR_W-1:0] addr_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_WDATA = 3'd3,
    S_WRITE = 3'd4,
    S_RREQ  = 3'd5,
    S_RWAIT = 3'd6,
    S_RSHOW = 3'd7
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_led;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  logic w_we;
  logic w_re;
  logic w_last;
  logic w_abort;

  assign w_we   = (r_state == S_WRITE);
  assign w_re   = (r_state == S_RREQ);
  assign w_last = (r_remaining == LEN_W'(1));

`ifdef SRAM_BURST_ABORT_EN
  assign w_abort = abort_pulse && (r_state != S_IDLE);
`else
  logic w_abort_unused;
  assign w_abort_unused = abort_pulse;
  assign w_abort        = 1'b0;
`endif

  // RAM contents survive reset, so the array carries no reset term.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[r_addr] <= r_wdata;
    if (w_re) r_rdata <= r_mem[r_addr];
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wdata     <= '0;
      r_led       <= '0;
    end else if (w_abort) begin
      // The WRITE-cycle write still commits through w_we; only RWAIT's capture needs keeping here.
      r_state <= S_IDLE;
      if (r_state == S_RWAIT) r_led <= r_rdata;
    end else begin
      case (r_state)
        S_IDLE: if (btn_pulse) begin
          r_mode  <= mode_wr;
          r_state <= S_ADDR;
        end
        S_ADDR: if (btn_pulse) begin
          r_addr  <= sw[ADDR_W-1:0];
          r_state <= S_LEN;
        end
        S_LEN: if (btn_pulse) begin
          r_remaining <= (sw[LEN_W-1:0] == '0) ? LEN_W'(1) : sw[LEN_W-1:0];
          r_state     <= r_mode ? S_WDATA : S_RREQ;
        end
        S_WDATA: if (btn_pulse) begin
          r_wdata <= sw;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
          r_state     <= w_last ? S_IDLE : S_WDATA;
        end
        S_RREQ:  r_state <= S_RWAIT;
        S_RWAIT: begin
          r_led   <= r_rdata;
          r_state <= S_RSHOW;
        end
        S_RSHOW: if (btn_pulse) begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
          r_state     <= w_last ? S_IDLE : S_RREQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign led     = r_led;
  assign busy    = (r_state != S_IDLE);
  assign state_o = r_state;
  assign addr_o  = r_addr;

endmodule
